movement_control: RTL and testbench

- Control FSM driving the 4-bit control code into the movement datapath (crosshair or bird) and consuming its `enable` draw-complete handshake.
- Paces each frame: hold → erase old sprite → apply requested moves → redraw → hold.
- One instance per sprite; the datapath instance it drives is selected by that datapath's own PorB input.

---
 rtl/movement_control_if.sv | 21 ++
 rtl/movement_control.sv | 57 +++++
 tb/tb_movement_control.sv | 97 +++++++++
 3 files changed

// File: rtl/movement_control_if.sv
// movement_control_if: request/handshake inputs and control/status outputs of the movement controller
interface movement_control_if;
  logic enable;
  logic req_left;
  logic req_right;
  logic req_down;
  logic req_up;
  logic pause;
  logic [3:0] control;
  logic busy;
  logic frame_done;
  logic timeout_err;
  modport master (
    input  enable, req_left, req_right, req_down, req_up, pause,
    output control, busy, frame_done, timeout_err
  );
  modport slave (
    output enable, req_left, req_right, req_down, req_up, pause,
    input  control, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/movement_control.sv
// movement_control: per-frame FSM pacing hold, erase, moves and redraw of one sprite datapath
module movement_control #(
  parameter int HOLD_CYCLES = 833334,
  parameter int CNT_W = 20,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset_n,
  movement_control_if.master m
);
  localparam int PW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] PREHOLD = 4'b0100, HOLD = 4'b0000, CLEAR = 4'b0001, LEFT = 4'b0011,
                         RIGHT = 4'b0010, DOWN = 4'b0110, UP = 4'b0111, DRAW = 4'b0101;
  localparam logic [CNT_W-1:0] HLAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PLAST = PW'(TIMEOUT - 1);
  logic [3:0] state, nxt, lat, pend, mv;
  logic [CNT_W-1:0] hold_cnt;
  logic [PW-1:0] phase;
  logic busy, frame_done, timeout_err, hs, hold_end, handshake_state;
  always_comb begin
    handshake_state = state == CLEAR || state == DRAW;
    // lat is {left, right, down, up}; the mask drops moves already visited this frame
    pend = lat & (state == CLEAR ? 4'b1111 : state == LEFT ? 4'b0111 :
                  state == RIGHT ? 4'b0011 : state == DOWN ? 4'b0001 : 4'b0000);
    mv = pend[3] ? LEFT : pend[2] ? RIGHT : pend[1] ? DOWN : pend[0] ? UP : DRAW;
    hs = (phase != '0 && m.enable) || phase == PLAST;
    hold_end = hold_cnt == HLAST && !m.pause;
    nxt = state == PREHOLD ? HOLD :
          state == HOLD ? (hold_end ? CLEAR : HOLD) :
          state == CLEAR ? (hs ? mv : CLEAR) :
          state == DRAW ? (hs ? HOLD : DRAW) :
          (state == LEFT || state == RIGHT || state == DOWN || state == UP) ? mv : PREHOLD;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PREHOLD;
      hold_cnt <= '0;
      phase <= '0;
      lat <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      hold_cnt <= (state != HOLD || hold_end) ? '0 : hold_cnt + CNT_W'(!m.pause);
      phase <= (handshake_state && nxt == state) ? phase + PW'(1) : '0;
      if (state == HOLD && hold_end) lat <= {m.req_left, m.req_right, m.req_down, m.req_up};
      busy <= nxt != PREHOLD && nxt != HOLD;
      frame_done <= state == DRAW && hs;
      timeout_err <= timeout_err | (handshake_state && phase == PLAST && !m.enable);
    end
  end
  assign m.control = state;
  assign m.busy = busy;
  assign m.frame_done = frame_done;
  assign m.timeout_err = timeout_err;
endmodule

// File: tb/tb_movement_control.sv
// tb_movement_control: directed frames with a queued scoreboard checked by an independent monitor
module tb_movement_control;
  localparam logic [3:0] PH = 4'b0100, HO = 4'b0000, CL = 4'b0001, LE = 4'b0011,
                         RI = 4'b0010, DN = 4'b0110, UPS = 4'b0111, DR = 4'b0101;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_exp = 1'b0;
  logic [6:0] q[$];
  int compared = 0;
  int mismatched = 0;
  event chk_ev;
  movement_control_if m();
  movement_control #(.HOLD_CYCLES(8), .CNT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .m(m));
  always #5 clk = ~clk;
  function automatic logic [6:0] ex(input logic [3:0] c, input logic fd);
    return {c, c != HO && c != PH, fd, err_exp};
  endfunction
  task automatic cyc(input logic [3:0] c, input int n, input logic fd);
    for (int i = 0; i < n; i++) begin
      q.push_back(ex(c, fd && i == 0));
      @(posedge clk);
      #2;
    end
  endtask
  initial begin : monitor
    logic [6:0] e, a;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {m.control, m.busy, m.frame_done, m.timeout_err};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL cmp%0d {control,busy,frame_done,timeout_err} got %b_%b%b%b required %b_%b%b%b at %0t",
                   compared, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0], $time);
        end
      end
    end
  end
  initial begin
    m.enable = 0; m.req_left = 0; m.req_right = 0; m.req_down = 0; m.req_up = 0; m.pause = 0;
    repeat (2) @(posedge clk);
    #2;
    q.push_back(ex(PH, 0)); ->chk_ev; #2;
    cyc(PH, 1, 0);
    reset_n = 1;
    cyc(HO, 8, 0);
    cyc(CL, 16, 0);
    err_exp = 1;
    cyc(DR, 16, 0);
    m.enable = 1;
    cyc(HO, 1, 1); cyc(HO, 7, 0); cyc(CL, 2, 0); cyc(DR, 2, 0);
    cyc(HO, 1, 1); cyc(HO, 7, 0);
    m.enable = 0; m.req_left = 1; m.req_up = 1;
    cyc(CL, 1, 0);
    m.req_left = 0; m.req_up = 0;
    cyc(CL, 3, 0);
    m.enable = 1;
    cyc(LE, 1, 0); cyc(UPS, 1, 0); cyc(DR, 2, 0);
    cyc(HO, 1, 1); cyc(HO, 7, 0);
    m.req_left = 1; m.req_right = 1;
    cyc(CL, 1, 0);
    m.req_left = 0; m.req_right = 0; m.req_down = 1;
    cyc(CL, 1, 0);
    m.req_down = 0;
    cyc(LE, 1, 0); cyc(RI, 1, 0); cyc(DR, 2, 0);
    cyc(HO, 1, 1); cyc(HO, 7, 0);
    m.req_left = 1; m.req_right = 1; m.req_down = 1; m.req_up = 1;
    cyc(CL, 1, 0);
    m.req_left = 0; m.req_right = 0; m.req_down = 0; m.req_up = 0;
    cyc(CL, 1, 0); cyc(LE, 1, 0); cyc(RI, 1, 0); cyc(DN, 1, 0); cyc(UPS, 1, 0); cyc(DR, 2, 0);
    cyc(HO, 1, 1); cyc(HO, 4, 0);
    m.pause = 1;
    cyc(HO, 10, 0);
    m.pause = 0;
    cyc(HO, 3, 0); cyc(CL, 1, 0);
    m.pause = 1;
    cyc(CL, 1, 0); cyc(DR, 1, 0);
    reset_n = 0; err_exp = 0;
    q.push_back(ex(PH, 0)); ->chk_ev; #2;
    m.pause = 0;
    cyc(PH, 2, 0);
    reset_n = 1;
    cyc(HO, 8, 0); cyc(CL, 2, 0); cyc(DR, 2, 0); cyc(HO, 1, 1); cyc(HO, 1, 0);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      mismatched += q.size();
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
